pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline-stage register that succeeds the fixed-width, always-enabled stage registers between decode/execute/memory/writeback. It carries a control bundle and a data bundle from one stage to the next with a valid/ready handshake, stalls without losing data, inserts bubbles, and supports a synchronous flush. A two-entry skid buffer keeps full throughput while `in_ready` stays registered, so there is no combinational ready path across stages.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_slot.sv | 32 +++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared bundle widths, D/E control bit positions and occupancy states for the
// elastic pipeline-stage registers.
package pipe_pkg;

    // Decode/execute bundles: ctrl = wreg,m2reg,wmem,aluc[3:0],aluimm,shift,jal
    // and data = a, b, imm, pc4 (4 x 32) plus rn (5).
    localparam int CTRL_W_DE = 10;
    localparam int DATA_W_DE = 133;
    localparam int CTRL_W_EM = 3;
    localparam int DATA_W_EM = 69;
    localparam int CTRL_W_MW = 2;
    localparam int DATA_W_MW = 69;

    localparam int DE_WREG    = 9;
    localparam int DE_M2REG   = 8;
    localparam int DE_WMEM    = 7;
    localparam int DE_ALUC_HI = 6;
    localparam int DE_ALUC_LO = 3;
    localparam int DE_ALUIMM  = 2;
    localparam int DE_SHIFT   = 1;
    localparam int DE_JAL     = 0;

    // Encoded as {skid valid, main valid}; 2'b10 is never reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

endpackage

// File: rtl/pipe_slot.sv
// One entry of the stage register: valid bit plus ctrl/data fields.
// Clear drops only the valid bit so the data fields keep their last value.
module pipe_slot #(
    parameter int CW = 10,
    parameter int DW = 133
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          load,
    input  logic          clear,
    input  logic [CW-1:0] in_ctrl,
    input  logic [DW-1:0] in_data,
    output logic          v,
    output logic [CW-1:0] ctrl,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v    <= 1'b0;
            ctrl <= '0;
            data <= '0;
        end else if (clear) begin
            v <= 1'b0;
        end else if (load) begin
            v    <= 1'b1;
            ctrl <= in_ctrl;
            data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic stage register with a two-entry skid buffer: main slot drives the
// outputs, skid slot absorbs the entry accepted while downstream stalls.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CW  = CTRL_W_DE,
    parameter int DW  = DATA_W_DE,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CW-1:0]  in_ctrl,
    input  logic [DW-1:0]  in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CW-1:0]  out_ctrl,
    output logic [DW-1:0]  out_data,
    output logic [SCW-1:0] stall_cnt
);

    logic          m_v, s_v;
    logic [CW-1:0] m_ctrl, s_ctrl, m_in_ctrl;
    logic [DW-1:0] m_data, s_data, m_in_data;
    logic          load_m, clear_m, load_s, clear_s, m_from_s;
    logic          acc, drn;
    state_t        state;

    // Occupancy is held in the slot valid bits; state is their concatenation.
    assign state = state_t'({s_v, m_v});

    assign in_ready  = !s_v && !flush;
    assign out_valid = m_v;
    assign out_ctrl  = m_v ? m_ctrl : '0;
    assign out_data  = m_data;
    assign acc       = in_valid && in_ready;
    assign drn       = m_v && out_ready;

    always_comb begin
        load_m   = 1'b0;
        clear_m  = 1'b0;
        load_s   = 1'b0;
        clear_s  = 1'b0;
        m_from_s = 1'b0;
        if (flush) begin
            clear_m = 1'b1;
            clear_s = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) load_m = 1'b1;
                end
                ONE: begin
                    if (acc && drn)  load_m  = 1'b1;
                    else if (acc)    load_s  = 1'b1;
                    else if (drn)    clear_m = 1'b1;
                end
                FULL: begin
                    if (drn) begin
                        load_m   = 1'b1;
                        m_from_s = 1'b1;
                        clear_s  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_in_ctrl = m_from_s ? s_ctrl : in_ctrl;
    assign m_in_data = m_from_s ? s_data : in_data;

    pipe_slot #(.CW(CW), .DW(DW)) u_main (
        .clk     (clk),
        .clrn    (clrn),
        .load    (load_m),
        .clear   (clear_m),
        .in_ctrl (m_in_ctrl),
        .in_data (m_in_data),
        .v       (m_v),
        .ctrl    (m_ctrl),
        .data    (m_data)
    );

    pipe_slot #(.CW(CW), .DW(DW)) u_skid (
        .clk     (clk),
        .clrn    (clrn),
        .load    (load_s),
        .clear   (clear_s),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .v       (s_v),
        .ctrl    (s_ctrl),
        .data    (s_data)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
        end else if (m_v && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    a_no_skid_only: assert property (@(posedge clk) disable iff (!clrn) !(s_v && !m_v));
    a_no_acc_full:  assert property (@(posedge clk) disable iff (!clrn) !((state == FULL) && acc));
    a_bubble_ctrl:  assert property (@(posedge clk) disable iff (!clrn) !out_valid |-> (out_ctrl == '0));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: the driver pushes expected entries, a
// negedge monitor pops and compares every completed output transfer.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         clrn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [9:0]   in_ctrl;
    logic [132:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [9:0]   out_ctrl;
    logic [132:0] out_data;
    logic [15:0]  stall_cnt;

    logic         sat_flush;
    logic         sat_in_valid;
    logic         sat_in_ready;
    logic [9:0]   sat_in_ctrl;
    logic [132:0] sat_in_data;
    logic         sat_out_valid;
    logic         sat_out_ready;
    logic [9:0]   sat_out_ctrl;
    logic [132:0] sat_out_data;
    logic [1:0]   sat_stall_cnt;

    logic [142:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.SCW(2)) u_sat (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (sat_flush),
        .in_valid  (sat_in_valid),
        .in_ready  (sat_in_ready),
        .in_ctrl   (sat_in_ctrl),
        .in_data   (sat_in_data),
        .out_valid (sat_out_valid),
        .out_ready (sat_out_ready),
        .out_ctrl  (sat_out_ctrl),
        .out_data  (sat_out_data),
        .stall_cnt (sat_stall_cnt)
    );

    task automatic chk(input string name, input logic [142:0] act, input logic [142:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [9:0] c, input logic [132:0] d,
                          input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic expect_out(input logic [9:0] c, input logic [132:0] d);
        exp_q.push_back({c, d});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer completes at the next posedge when valid & ready.
    always @(negedge clk) begin
        if (clrn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h expected none", {out_ctrl, out_data});
            end else begin
                chk("out_entry", {out_ctrl, out_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn          = 1'b0;
        sat_flush     = 1'b0;
        sat_in_valid  = 1'b0;
        sat_in_ctrl   = '0;
        sat_in_data   = '0;
        sat_out_ready = 1'b0;
        set_in(1'b1, 10'h005, 133'hAB, 1'b1, 1'b0);

        // Reset with in_valid high, then the first entry one cycle later
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 143'(out_valid), 143'(0));
        chk("rst_out_ctrl",  143'(out_ctrl),  143'(0));
        chk("rst_out_data",  143'(out_data),  143'(0));
        chk("rst_in_ready",  143'(in_ready),  143'(1));
        chk("rst_stall_cnt", 143'(stall_cnt), 143'(0));
        next_cycle();
        clrn = 1'b1;
        expect_out(10'h005, 133'hAB);
        next_cycle();
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("first_valid", 143'(out_valid), 143'(1));
        chk("first_data",  143'(out_data),  143'(133'hAB));
        next_cycle();

        // Streaming 1..8 with out_ready high
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                set_in(1'b1, 10'(10'h100 + i + 1), 133'(i + 1), 1'b1, 1'b0);
                expect_out(10'(10'h100 + i + 1), 133'(i + 1));
            end else begin
                set_in(1'b0, '0, '0, 1'b1, 1'b0);
            end
            @(negedge clk);
            chk("stream_in_ready", 143'(in_ready), 143'(1));
            if (i > 0) chk("stream_out_valid", 143'(out_valid), 143'(1));
            next_cycle();
        end
        chk("stream_stall_cnt", 143'(stall_cnt), 143'(0));

        // Back-pressure: 1 in M, 2 in S, 3 held upstream, three stall cycles
        expect_out(10'h011, 133'd1);
        expect_out(10'h012, 133'd2);
        expect_out(10'h013, 133'd3);
        set_in(1'b1, 10'h011, 133'd1, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 10'h012, 133'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_one", 143'(in_ready), 143'(1));
        next_cycle();
        set_in(1'b1, 10'h013, 133'd3, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_full", 143'(in_ready), 143'(0));
        chk("bp_hold_m",        143'(out_data), 143'(133'd1));
        next_cycle();
        @(negedge clk);
        chk("bp_in_ready_full2", 143'(in_ready), 143'(0));
        next_cycle();
        set_in(1'b1, 10'h013, 133'd3, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_stall_cnt", 143'(stall_cnt), 143'(3));
        next_cycle();
        @(negedge clk);
        chk("bp_in_ready_back", 143'(in_ready), 143'(1));
        next_cycle();
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("bp_drained", 143'(out_valid), 143'(0));
        next_cycle();

        // Flush while FULL with 9 presented; 4 and 5 are discarded
        set_in(1'b1, 10'h004, 133'd4, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 10'h005, 133'd5, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 10'h209, 133'd9, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_in_ready", 143'(in_ready), 143'(0));
        next_cycle();
        expect_out(10'h209, 133'd9);
        set_in(1'b1, 10'h209, 133'd9, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_out_valid", 143'(out_valid), 143'(0));
        chk("flush_out_ctrl",  143'(out_ctrl),  143'(0));
        chk("flush_in_ready2", 143'(in_ready),  143'(1));
        chk("flush_data_kept", 143'(out_data),  143'(133'd4));
        next_cycle();
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_9_valid",    143'(out_valid), 143'(1));
        chk("flush_stall_kept", 143'(stall_cnt), 143'(5));
        next_cycle();

        // Bubble between wreg entries
        expect_out(10'h200, 133'h11);
        expect_out(10'h201, 133'h22);
        set_in(1'b1, 10'h200, 133'h11, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b1, 10'h201, 133'h22, 1'b1, 1'b0);
        @(negedge clk);
        chk("bubble_valid", 143'(out_valid), 143'(0));
        chk("bubble_ctrl",  143'(out_ctrl),  143'(0));
        chk("bubble_data",  143'(out_data),  143'(133'h11));
        next_cycle();
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();

        // Saturation of a 2-bit stall counter
        sat_in_valid = 1'b1;
        sat_in_ctrl  = 10'h003;
        sat_in_data  = 133'h77;
        next_cycle();
        sat_in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("sat_stall_cnt", 143'(sat_stall_cnt), 143'((k > 3) ? 3 : k));
            next_cycle();
        end
        chk("sat_out_valid", 143'(sat_out_valid), 143'(1));
        chk("sat_out_ctrl",  143'(sat_out_ctrl),  143'(10'h003));
        chk("sat_out_data",  143'(sat_out_data),  143'(133'h77));
        chk("sat_in_ready",  143'(sat_in_ready),  143'(1));

        chk("queue_empty", 143'(exp_q.size()), 143'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
